// File: rtl/ifsram_bank_arbiter.sv
// Ping-pong arbiter for the two input-feature SRAM banks: hands FREE banks to the fill
// engine and FULL banks to the row reader in strict alternation, and flags layer completion.
module ifsram_bank_arbiter #(
   parameter int unsigned RowsPerBank = 3,
   parameter int unsigned RowW        = 5
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            cfg_start_i,
   input  logic [RowW-1:0] cfg_row_total_i,
   input  logic            wr_req_i,
   input  logic            wr_done_i,
   output logic            wr_grant_o,
   output logic            wr_bank_o,
   output logic [RowW-1:0] wr_rows_o,
   input  logic            rd_req_i,
   input  logic            rd_done_i,
   output logic            rd_grant_o,
   output logic            rd_bank_o,
   output logic [RowW-1:0] rd_rows_o,
   output logic            busy_o,
   output logic            layer_done_o,
   output logic            proto_err_o,
   output logic [3:0]      bank_state_o
);

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

   localparam logic [1:0] BankFree     = 2'd0;
   localparam logic [1:0] BankFilling  = 2'd1;
   localparam logic [1:0] BankFull     = 2'd2;
   localparam logic [1:0] BankDraining = 2'd3;

   localparam logic [RowW-1:0] FillMax = RowW'(RowsPerBank);

   state_e                 state_q, state_d;
   logic [RowW-1:0]        total_q, total_d;
   logic [RowW-1:0]        issued_q, issued_d;
   logic                   wr_ptr_q, wr_ptr_d;
   logic                   rd_ptr_q, rd_ptr_d;
   logic [1:0][1:0]        bank_q, bank_d;
   logic [1:0][RowW-1:0]   rows_q, rows_d;
   logic                   wr_out_q, wr_out_d;
   logic                   rd_out_q, rd_out_d;
   logic                   wr_grant_q, wr_grant_d;
   logic                   rd_grant_q, rd_grant_d;
   logic                   wr_bank_q, wr_bank_d;
   logic                   rd_bank_q, rd_bank_d;
   logic [RowW-1:0]        wr_rows_q, wr_rows_d;
   logic [RowW-1:0]        rd_rows_q, rd_rows_d;
   logic                   proto_err_q, proto_err_d;

   logic [RowW-1:0]        remaining;
   logic [RowW-1:0]        fill_rows;
   logic                   wr_go;
   logic                   rd_go;
   logic                   quiet;

   always_comb begin
      state_d     = state_q;
      total_d     = total_q;
      issued_d    = issued_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      bank_d      = bank_q;
      rows_d      = rows_q;
      wr_out_d    = wr_out_q;
      rd_out_d    = rd_out_q;
      wr_grant_d  = 1'b0;
      rd_grant_d  = 1'b0;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_rows_d   = wr_rows_q;
      rd_rows_d   = rd_rows_q;
      proto_err_d = proto_err_q;

      remaining = total_q - issued_q;
      fill_rows = (remaining < FillMax) ? remaining : FillMax;

      // All decisions look only at registered bank state; no same-cycle bypass.
      wr_go = (state_q == StRun) && wr_req_i && !wr_out_q &&
              (bank_q[wr_ptr_q] == BankFree) && (issued_q < total_q);
      rd_go = ((state_q == StRun) || (state_q == StFlush)) && rd_req_i && !rd_out_q &&
              (bank_q[rd_ptr_q] == BankFull);
      quiet = (bank_q[0] == BankFree) && (bank_q[1] == BankFree) && !wr_grant_q &&
              !rd_grant_q && !wr_out_q && !rd_out_q;

      unique case (state_q)
         StIdle: begin
            if (cfg_start_i) begin
               state_d  = StRun;
               total_d  = cfg_row_total_i;
               issued_d = '0;
               wr_ptr_d = 1'b0;
               rd_ptr_d = 1'b0;
            end
         end
         StRun:   if (issued_q >= total_q) state_d = StFlush;
         StFlush: if (quiet) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (wr_done_i) begin
         if (wr_out_q) begin
            bank_d[wr_bank_q] = BankFull;
            wr_out_d          = 1'b0;
         end else begin
            proto_err_d = 1'b1;
         end
      end

      if (rd_done_i) begin
         if (rd_out_q) begin
            bank_d[rd_bank_q] = BankFree;
            rd_out_d          = 1'b0;
         end else begin
            proto_err_d = 1'b1;
         end
      end

      if (wr_go) begin
         wr_grant_d       = 1'b1;
         wr_bank_d        = wr_ptr_q;
         wr_rows_d        = fill_rows;
         rows_d[wr_ptr_q] = fill_rows;
         bank_d[wr_ptr_q] = BankFilling;
         issued_d         = issued_q + fill_rows;
         wr_ptr_d         = ~wr_ptr_q;
         wr_out_d         = 1'b1;
      end

      if (rd_go) begin
         rd_grant_d       = 1'b1;
         rd_bank_d        = rd_ptr_q;
         rd_rows_d        = rows_q[rd_ptr_q];
         bank_d[rd_ptr_q] = BankDraining;
         rd_ptr_d         = ~rd_ptr_q;
         rd_out_d         = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         total_q     <= '0;
         issued_q    <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         bank_q      <= '0;
         rows_q      <= '0;
         wr_out_q    <= 1'b0;
         rd_out_q    <= 1'b0;
         wr_grant_q  <= 1'b0;
         rd_grant_q  <= 1'b0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_rows_q   <= '0;
         rd_rows_q   <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         total_q     <= total_d;
         issued_q    <= issued_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         bank_q      <= bank_d;
         rows_q      <= rows_d;
         wr_out_q    <= wr_out_d;
         rd_out_q    <= rd_out_d;
         wr_grant_q  <= wr_grant_d;
         rd_grant_q  <= rd_grant_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_rows_q   <= wr_rows_d;
         rd_rows_q   <= rd_rows_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign wr_grant_o   = wr_grant_q;
   assign wr_bank_o    = wr_bank_q;
   assign wr_rows_o    = wr_rows_q;
   assign rd_grant_o   = rd_grant_q;
   assign rd_bank_o    = rd_bank_q;
   assign rd_rows_o    = rd_rows_q;
   assign busy_o       = (state_q != StIdle);
   assign layer_done_o = (state_q == StDone);
   assign proto_err_o  = proto_err_q;
   assign bank_state_o = bank_q;

endmodule

// File: tb/tb_ifsram_bank_arbiter.sv
// Scoreboard bench for ifsram_bank_arbiter: stimulus queues expected grants, a monitor
// pops and compares them whenever a grant pulse appears.
module tb_ifsram_bank_arbiter;

   localparam int unsigned RowW    = 5;
   localparam int          DoneLat = 4;

   typedef struct packed {
      logic            bank;
      logic [RowW-1:0] rows;
   } grant_t;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            cfg_start_i = 1'b0;
   logic [RowW-1:0] cfg_row_total_i = '0;
   logic            wr_req_i = 1'b0;
   logic            wr_done_i = 1'b0;
   logic            wr_grant_o;
   logic            wr_bank_o;
   logic [RowW-1:0] wr_rows_o;
   logic            rd_req_i = 1'b0;
   logic            rd_done_i = 1'b0;
   logic            rd_grant_o;
   logic            rd_bank_o;
   logic [RowW-1:0] rd_rows_o;
   logic            busy_o;
   logic            layer_done_o;
   logic            proto_err_o;
   logic [3:0]      bank_state_o;

   ifsram_bank_arbiter #(
      .RowsPerBank(3),
      .RowW       (RowW)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .cfg_start_i    (cfg_start_i),
      .cfg_row_total_i(cfg_row_total_i),
      .wr_req_i       (wr_req_i),
      .wr_done_i      (wr_done_i),
      .wr_grant_o     (wr_grant_o),
      .wr_bank_o      (wr_bank_o),
      .wr_rows_o      (wr_rows_o),
      .rd_req_i       (rd_req_i),
      .rd_done_i      (rd_done_i),
      .rd_grant_o     (rd_grant_o),
      .rd_bank_o      (rd_bank_o),
      .rd_rows_o      (rd_rows_o),
      .busy_o         (busy_o),
      .layer_done_o   (layer_done_o),
      .proto_err_o    (proto_err_o),
      .bank_state_o   (bank_state_o)
   );

   always #5 clk_i = ~clk_i;

   grant_t wr_q[$];
   grant_t rd_q[$];

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_wr = 0;
   int n_rd = 0;
   int n_ld = 0;
   int last_wr_cyc = -1;
   int rd_done_cyc = -1;
   int wr_cnt = 0;
   int rd_cnt = 0;
   bit auto_wr = 1'b0;
   bit auto_rd = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic bank, input logic [RowW-1:0] rows);
      grant_t g;
      g.bank = bank;
      g.rows = rows;
      wr_q.push_back(g);
      rd_q.push_back(g);
   endtask

   // One clock; pulses clear, then the auto writer/reader answer DoneLat cycles after a grant.
   task automatic tick();
      @(posedge clk_i);
      #1;
      cyc++;
      cfg_start_i = 1'b0;
      wr_done_i   = 1'b0;
      rd_done_i   = 1'b0;
      if (auto_wr) begin
         if (wr_grant_o) wr_cnt = DoneLat;
         else if (wr_cnt > 0) begin
            wr_cnt--;
            if (wr_cnt == 0) wr_done_i = 1'b1;
         end
      end
      if (auto_rd) begin
         if (rd_grant_o) rd_cnt = DoneLat;
         else if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               rd_done_i   = 1'b1;
               rd_done_cyc = cyc;
            end
         end
      end
   endtask

   task automatic start(input int total);
      cfg_start_i     = 1'b1;
      cfg_row_total_i = RowW'(total);
      tick();
   endtask

   task automatic wait_layer(input string name);
      int guard = 0;
      while (!layer_done_o && guard < 300) begin
         tick();
         guard++;
      end
      check({name, " layer_done reached"}, int'(layer_done_o), 1);
      tick();
      tick();
   endtask

   task automatic check_queues(input string name);
      check({name, " wr queue drained"}, wr_q.size(), 0);
      check({name, " rd queue drained"}, rd_q.size(), 0);
   endtask

   initial begin : monitor
      grant_t eg;
      forever begin
         @(negedge clk_i);
         if (rst_ni) begin
            if (wr_grant_o) begin
               n_wr++;
               last_wr_cyc = cyc;
               if (wr_q.size() == 0) check("wr_grant unexpected", 1, 0);
               else begin
                  eg = wr_q.pop_front();
                  check("wr_bank", int'(wr_bank_o), int'(eg.bank));
                  check("wr_rows", int'(wr_rows_o), int'(eg.rows));
               end
            end
            if (rd_grant_o) begin
               n_rd++;
               if (rd_q.size() == 0) check("rd_grant unexpected", 1, 0);
               else begin
                  eg = rd_q.pop_front();
                  check("rd_bank", int'(rd_bank_o), int'(eg.bank));
                  check("rd_rows", int'(rd_rows_o), int'(eg.rows));
               end
            end
            if (layer_done_o) n_ld++;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int ld0;
      int wr0;
      int rd0;
      int guard;

      // Reset state
      #3;
      check("reset outputs", int'({wr_grant_o, wr_bank_o, wr_rows_o, rd_grant_o, rd_bank_o,
                                   rd_rows_o, busy_o, layer_done_o, proto_err_o,
                                   bank_state_o}), 0);
      repeat (2) @(posedge clk_i);
      #2;
      rst_ni = 1'b1;
      tick();
      check("post-reset busy", int'(busy_o), 0);
      check("post-reset bank_state", int'(bank_state_o), 0);

      // 1: total=16, both sides always ready
      ld0 = n_ld;
      push_exp(1'b0, 5'd3);
      push_exp(1'b1, 5'd3);
      push_exp(1'b0, 5'd3);
      push_exp(1'b1, 5'd3);
      push_exp(1'b0, 5'd3);
      push_exp(1'b1, 5'd1);
      auto_wr  = 1'b1;
      auto_rd  = 1'b1;
      wr_req_i = 1'b1;
      rd_req_i = 1'b1;
      start(16);
      check("t1 busy after start", int'(busy_o), 1);
      wait_layer("t1");
      check("t1 layer_done count", n_ld - ld0, 1);
      check_queues("t1");
      check("t1 proto_err", int'(proto_err_o), 0);

      // 2: reader stalled after two fills
      ld0 = n_ld;
      wr0 = n_wr;
      push_exp(1'b0, 5'd3);
      push_exp(1'b1, 5'd3);
      push_exp(1'b0, 5'd3);
      rd_req_i = 1'b0;
      start(9);
      repeat (30) tick();
      check("t2 fills before drain", n_wr - wr0, 2);
      check("t2 both banks full", int'(bank_state_o), 10);
      rd_done_cyc = -1;
      rd_req_i    = 1'b1;
      guard       = 0;
      while (rd_done_cyc < 0 && guard < 50) begin
         tick();
         guard++;
      end
      check("t2 bank0 rd_done seen", int'(rd_done_cyc >= 0), 1);
      guard = 0;
      while ((n_wr - wr0) < 3 && guard < 20) begin
         tick();
         guard++;
      end
      check("t2 third wr_grant issued", n_wr - wr0, 3);
      check("t2 wr_grant cycles after rd_done", last_wr_cyc - rd_done_cyc, 2);
      wait_layer("t2");
      check("t2 layer_done count", n_ld - ld0, 1);
      check_queues("t2");

      // 3: wr_done and rd_req in the same cycle
      ld0      = n_ld;
      auto_wr  = 1'b0;
      auto_rd  = 1'b0;
      wr_req_i = 1'b1;
      rd_req_i = 1'b0;
      push_exp(1'b0, 5'd3);
      start(3);
      guard = 0;
      while (!wr_grant_o && guard < 10) begin
         tick();
         guard++;
      end
      check("t3 wr_grant seen", int'(wr_grant_o), 1);
      wr_req_i = 1'b0;
      tick();
      tick();
      wr_done_i = 1'b1;
      rd_req_i  = 1'b1;
      tick();
      check("t3 no rd_grant yet", int'(rd_grant_o), 0);
      check("t3 bank0 full", int'(bank_state_o), 2);
      tick();
      check("t3 rd_grant", int'(rd_grant_o), 1);
      check("t3 bank0 draining", int'(bank_state_o), 3);
      rd_req_i = 1'b0;
      tick();
      tick();
      rd_done_i = 1'b1;
      wait_layer("t3");
      check("t3 layer_done count", n_ld - ld0, 1);
      check_queues("t3");
      check("t3 proto_err", int'(proto_err_o), 0);

      // 5: empty layer
      ld0      = n_ld;
      wr0      = n_wr;
      rd0      = n_rd;
      wr_req_i = 1'b1;
      rd_req_i = 1'b1;
      start(0);
      check("t5 c1 busy", int'(busy_o), 1);
      check("t5 c1 layer_done", int'(layer_done_o), 0);
      tick();
      check("t5 c2 busy", int'(busy_o), 1);
      check("t5 c2 layer_done", int'(layer_done_o), 0);
      tick();
      check("t5 c3 busy", int'(busy_o), 1);
      check("t5 c3 layer_done", int'(layer_done_o), 1);
      tick();
      check("t5 c4 busy", int'(busy_o), 0);
      check("t5 c4 layer_done", int'(layer_done_o), 0);
      tick();
      check("t5 layer_done count", n_ld - ld0, 1);
      check("t5 wr grants", n_wr - wr0, 0);
      check("t5 rd grants", n_rd - rd0, 0);
      check("t5 proto_err", int'(proto_err_o), 0);

      // 4: stray wr_done in IDLE
      wr0       = n_wr;
      wr_done_i = 1'b1;
      tick();
      check("t4 proto_err set", int'(proto_err_o), 1);
      check("t4 bank_state", int'(bank_state_o), 0);
      repeat (4) tick();
      check("t4 proto_err sticky", int'(proto_err_o), 1);
      check("t4 no wr grants", n_wr - wr0, 0);
      check("t4 busy", int'(busy_o), 0);

      // 6: reset while bank0 is draining, then a fresh layer
      push_exp(1'b0, 5'd3);
      push_exp(1'b1, 5'd3);
      push_exp(1'b0, 5'd3);
      auto_wr  = 1'b1;
      auto_rd  = 1'b1;
      wr_req_i = 1'b1;
      rd_req_i = 1'b1;
      start(9);
      guard = 0;
      while (bank_state_o[1:0] != 2'd3 && guard < 50) begin
         tick();
         guard++;
      end
      check("t6 bank0 draining", int'(bank_state_o[1:0]), 3);
      #2;
      rst_ni = 1'b0;
      #1;
      check("t6 async reset outputs", int'({wr_grant_o, wr_bank_o, wr_rows_o, rd_grant_o,
                                            rd_bank_o, rd_rows_o, busy_o, layer_done_o,
                                            proto_err_o, bank_state_o}), 0);
      auto_wr  = 1'b0;
      auto_rd  = 1'b0;
      wr_cnt   = 0;
      rd_cnt   = 0;
      wr_req_i = 1'b0;
      rd_req_i = 1'b0;
      tick();
      tick();
      wr_q.delete();
      rd_q.delete();
      rst_ni = 1'b1;
      tick();
      check("t6 idle after reset", int'(busy_o), 0);
      ld0 = n_ld;
      push_exp(1'b0, 5'd3);
      push_exp(1'b1, 5'd1);
      auto_wr  = 1'b1;
      auto_rd  = 1'b1;
      wr_req_i = 1'b1;
      rd_req_i = 1'b1;
      start(4);
      wait_layer("t6");
      check("t6 layer_done count", n_ld - ld0, 1);
      check_queues("t6");
      check("t6 proto_err", int'(proto_err_o), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
